// File: rtl/sipo_deserializer_pkg.sv
// Shared definitions for the SIPO deserializer: FSM state encoding and default word width.
package sipo_deserializer_pkg;

   localparam int DEFAULT_WIDTH = 8;

   // 2'b11 has no name; the FSM maps it back to ST_IDLE.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/sipo_bit_counter.sv
// Frame bit counter: counts captured bits, wraps after the last bit and flags the final position.
module sipo_bit_counter
   import sipo_deserializer_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   localparam int CW    = $clog2(WIDTH)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clr,
   input  logic          en,
   output logic [CW-1:0] cnt,
   output logic          last
);

   assign last = (cnt == CW'(WIDTH - 1));

   // A clear coinciding with a captured bit restarts the count at 1, which is how
   // a start edge that also carries bit 0 is accounted for.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  cnt <= '0;
      else if (clr)  cnt <= en ? CW'(1) : '0;
      else if (en)   cnt <= last ? '0 : cnt + CW'(1);
   end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: start-framed bit stream in, WIDTH-bit words out with a one-cycle valid.
module sipo_deserializer
   import sipo_deserializer_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clear,
   input  logic                     start,
   input  logic                     d_in,
   input  logic                     d_valid,
   output logic [WIDTH-1:0]         q_data,
   output logic                     q_valid,
   output logic                     busy,
   output logic [$clog2(WIDTH)-1:0] bit_cnt
);

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   sr, sr_base, sr_shift;
   logic               capture, word_done, last;

   // A start edge discards the partial word, so the shift operates on zero instead of sr.
   always_comb begin
      sr_base  = start ? '0 : sr;
      sr_shift = MSB_FIRST ? {sr_base[WIDTH-2:0], d_in} : {d_in, sr_base[WIDTH-1:1]};
   end

   assign capture   = !clear && d_valid && (start || state == ST_SHIFT);
   assign word_done = capture && !start && last;

   sipo_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clear || start),
      .en      (capture),
      .cnt     (bit_cnt),
      .last    (last)
   );

   // NOTE: state-holding logic uses non-blocking assignments so every register samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= ST_IDLE;
         sr     <= '0;
         q_data <= '0;
      end else begin
         state <= state_nxt;
         if (clear)        sr <= '0;
         else if (capture) sr <= sr_shift;
         else if (start)   sr <= '0;
         if (word_done)    q_data <= sr_shift;
      end
   end

   // NOTE: state_nxt gets a value before any branching, so no path can leave it
   // unassigned and infer a latch; this default also recovers the unused encoding.
   always_comb begin
      state_nxt = ST_IDLE;
      if (clear)      state_nxt = ST_IDLE;
      else if (start) state_nxt = ST_SHIFT;
      else begin
         case (state)
            ST_SHIFT: state_nxt = word_done ? ST_DONE : ST_SHIFT;
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   assign q_valid = (state == ST_DONE);
   assign busy    = (state == ST_SHIFT);

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench: MSB-first and LSB-first instances share one stimulus stream; monitors pop expected words on q_valid.
module tb_sipo_deserializer;

   logic       clk = 1'b0;
   logic       reset_n, clear, start, d_in, d_valid;
   logic [7:0] q_m, q_l;
   logic       v_m, v_l, b_m, b_l;
   logic [2:0] c_m, c_l;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int pulses_m = 0, pulses_l = 0;
   int last_pulse = 0, gap = 0;
   logic [7:0] exp_m[$];
   logic [7:0] exp_l[$];

   sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .reset_n(reset_n), .clear(clear), .start(start), .d_in(d_in), .d_valid(d_valid),
      .q_data(q_m), .q_valid(v_m), .busy(b_m), .bit_cnt(c_m)
   );

   sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .reset_n(reset_n), .clear(clear), .start(start), .d_in(d_in), .d_valid(d_valid),
      .q_data(q_l), .q_valid(v_l), .busy(b_l), .bit_cnt(c_l)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(negedge clk);
      if (v_m === 1'b1) begin
         pulses_m++;
         gap = cyc - last_pulse;
         last_pulse = cyc;
         if (exp_m.size() == 0) check("msb unexpected q_valid", {7'd0, v_m}, 8'd0);
         else                   check("msb q_data", q_m, exp_m.pop_front());
      end
   end

   initial forever begin
      @(negedge clk);
      if (v_l === 1'b1) begin
         pulses_l++;
         if (exp_l.size() == 0) check("lsb unexpected q_valid", {7'd0, v_l}, 8'd0);
         else                   check("lsb q_data", q_l, exp_l.pop_front());
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         start = 1'b0; d_valid = 1'b0; clear = 1'b0; d_in = 1'b0;
      end
   endtask

   // Sends the top nbits of w, MSB of w first, with gap idle cycles between bits.
   task automatic send(input logic [7:0] w, input int nbits, input int gap_len, input bit with_start);
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         clear = 1'b0; start = with_start && (i == 0); d_valid = 1'b1; d_in = w[7-i];
         if (i < nbits - 1)
            for (int g = 0; g < gap_len; g++) begin
               @(negedge clk);
               start = 1'b0; d_valid = 1'b0;
            end
      end
   endtask

   task automatic expect_word(input logic [7:0] m, input logic [7:0] l);
      exp_m.push_back(m);
      exp_l.push_back(l);
   endtask

   initial begin
      reset_n = 1'b0; clear = 1'b0; start = 1'b0; d_in = 1'b0; d_valid = 1'b0;
      idle(2);
      check("reset q_data", q_m, 8'h00);
      check("reset q_valid", {7'd0, v_m}, 8'd0);
      check("reset busy", {7'd0, b_m}, 8'd0);
      check("reset bit_cnt", 8'(c_m), 8'd0);
      @(negedge clk) reset_n = 1'b1;

      // d_valid without start must be ignored in IDLE
      send(8'hFF, 3, 0, 1'b0);
      idle(2);
      check("idle ignore bit_cnt", 8'(c_m), 8'd0);
      check("idle ignore busy", {7'd0, b_m}, 8'd0);

      // bits 1,0,1,1,0,0,1,0 back to back
      expect_word(8'hB2, 8'h4D);
      send(8'hB2, 8, 0, 1'b1);
      idle(2);
      check("busy after frame", {7'd0, b_m}, 8'd0);
      check("pulses after frame 1", 8'(pulses_m), 8'd1);

      // same stream with 3-cycle gaps
      expect_word(8'hB2, 8'h4D);
      send(8'hB2, 8, 3, 1'b1);
      idle(2);
      check("pulses after gapped frame", 8'(pulses_m), 8'd2);
      check("lsb pulses after gapped frame", 8'(pulses_l), 8'd2);

      // restart after 5 bits, then a full 0xFF frame
      send(8'h00, 5, 0, 1'b1);
      expect_word(8'hFF, 8'hFF);
      send(8'hFF, 8, 0, 1'b1);
      idle(2);
      check("pulses after restart", 8'(pulses_m), 8'd3);

      // 4-bit frame aborted by clear; further bits without start are ignored
      send(8'h00, 4, 0, 1'b1);
      @(negedge clk);
      clear = 1'b1; start = 1'b0; d_valid = 1'b0;
      send(8'h00, 4, 0, 1'b0);
      idle(3);
      check("clear q_data held", q_m, 8'hFF);
      check("clear lsb q_data held", q_l, 8'hFF);
      check("clear bit_cnt", 8'(c_m), 8'd0);
      check("pulses after clear", 8'(pulses_m), 8'd3);

      // back-to-back frames: second start lands in DONE
      expect_word(8'hA5, 8'hA5);
      expect_word(8'h3C, 8'h3C);
      send(8'hA5, 8, 0, 1'b1);
      send(8'h3C, 8, 0, 1'b1);
      idle(2);
      check("pulses after back-to-back", 8'(pulses_m), 8'd5);
      check("back-to-back pulse spacing", 8'(gap), 8'd8);

      // async reset between edges after 6 bits
      send(8'h00, 6, 0, 1'b1);
      @(negedge clk);
      d_valid = 1'b0; start = 1'b0;
      check("mid-frame bit_cnt", 8'(c_m), 8'd6);
      check("mid-frame busy", {7'd0, b_m}, 8'd1);
      #2 reset_n = 1'b0;
      #1;
      check("async reset q_data", q_m, 8'h00);
      check("async reset bit_cnt", 8'(c_m), 8'd0);
      check("async reset busy", {7'd0, b_m}, 8'd0);
      @(negedge clk) reset_n = 1'b1;
      expect_word(8'h81, 8'h81);
      send(8'h81, 8, 0, 1'b1);
      idle(3);
      check("final q_data", q_m, 8'h81);
      check("pulses at end", 8'(pulses_m), 8'd6);
      check("lsb pulses at end", 8'(pulses_l), 8'd6);
      check("msb scoreboard drained", 8'(exp_m.size()), 8'd0);
      check("lsb scoreboard drained", 8'(exp_l.size()), 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
